// File: rtl/fc_layer_tm_pkg.sv
// Shared definitions for the time-multiplexed fully-connected layer:
// FSM state encoding, activation mode codes, default fixed-point constants.
package fc_layer_tm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_B,
        LD_W,
        RX,
        MAC,
        OUT
    } state_t;

    localparam int ACT_NONE  = 0;
    localparam int ACT_RELU  = 1;
    localparam int ACT_LEAKY = 2;

    localparam int DEF_FRAC      = 15;
    localparam int DEF_NEG_SLOPE = 327;

    // Counter width that never collapses to zero bits.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_act_unit.sv
// Bias add followed by the selected activation (none / ReLU / LeakyReLU).
// Ports: acc, bias (DW words in) -> y (activated DW word out). Combinational.
module fc_act_unit
    import fc_layer_tm_pkg::*;
#(
    parameter int DW        = 32,
    parameter int FRAC      = DEF_FRAC,
    parameter int ACT_MODE  = ACT_LEAKY,
    parameter int NEG_SLOPE = DEF_NEG_SLOPE
) (
    input  logic [DW-1:0] acc,
    input  logic [DW-1:0] bias,
    output logic [DW-1:0] y
);

    localparam logic signed [2*DW-1:0] SLOPE = (2*DW)'(NEG_SLOPE);

    logic [DW-1:0]          sum;
    logic signed [2*DW-1:0] sext;

    always_comb begin
        // Wraps modulo 2^DW by design; no saturation.
        sum  = acc + bias;
        sext = {{DW{sum[DW-1]}}, sum};
        y    = sum;
        if (sum[DW-1]) begin
            if (ACT_MODE == ACT_RELU) begin
                y = '0;
            end else if (ACT_MODE == ACT_LEAKY) begin
                y = DW'((sext * SLOPE) >>> FRAC);
            end
        end
    end

endmodule

// File: rtl/fc_layer_tm.sv
// Time-multiplexed fully-connected layer: loads biases/weights, buffers one
// input vector, then computes OUT_CH neurons with IN_CH multipliers.
// Ports: clk, RSTn (sync, active-low), i_EN_w / i_EN_c start load / inference,
// i_data/i_stb_in/o_ack_in input stream, o_data/o_stb_out/i_ack_out result,
// o_busy (not idle), o_w_valid (a complete parameter load is held).
module fc_layer_tm
    import fc_layer_tm_pkg::*;
#(
    parameter int DW        = 32,
    parameter int FRAC      = DEF_FRAC,
    parameter int IN_CH     = 4,
    parameter int IN_SEQ    = 23,
    parameter int OUT_CH    = 16,
    parameter int ACT_MODE  = ACT_LEAKY,
    parameter int NEG_SLOPE = DEF_NEG_SLOPE
) (
    input  logic                 clk,
    input  logic                 RSTn,
    input  logic                 i_EN_w,
    input  logic                 i_EN_c,
    output logic                 o_busy,
    output logic                 o_w_valid,
    input  logic [DW*IN_CH-1:0]  i_data,
    input  logic                 i_stb_in,
    output logic                 o_ack_in,
    output logic [DW*OUT_CH-1:0] o_data,
    output logic                 o_stb_out,
    input  logic                 i_ack_out
);

    localparam int NB  = OUT_CH / IN_CH;
    localparam int NW  = OUT_CH * IN_SEQ;
    localparam int BW  = cw(NB);
    localparam int WW  = cw(NW);
    localparam int SW  = cw(IN_SEQ);
    localparam int KW  = cw(IN_CH);
    localparam int NNW = cw(OUT_CH);

    logic [DW-1:0] bias_mem [NB][IN_CH];
    logic [DW-1:0] w_mem    [NW][IN_CH];
    logic [DW-1:0] x_mem    [IN_SEQ][IN_CH];
    logic [DW-1:0] res      [OUT_CH];
    logic [DW-1:0] lane     [IN_CH];

    state_t         state;
    logic [BW-1:0]  b_cnt;
    logic [WW-1:0]  w_cnt;
    logic [SW-1:0]  s_cnt;
    logic [NNW-1:0] n_cnt;
    logic [BW-1:0]  n_row;
    logic [KW-1:0]  n_col;
    logic           wr_pend;
    logic [NNW-1:0] wr_n;
    logic [BW-1:0]  wr_row;
    logic [KW-1:0]  wr_col;
    logic [1:0]     tail;
    logic [DW-1:0]  acc;
    logic [DW-1:0]  mac_sum;
    logic [DW-1:0]  act_y;
    logic           xfer;

    function automatic logic [DW-1:0] prod(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b
    );
        logic signed [2*DW-1:0] ae;
        logic signed [2*DW-1:0] be;
        ae = {{DW{a[DW-1]}}, a};
        be = {{DW{b[DW-1]}}, b};
        return DW'((ae * be) >>> FRAC);
    endfunction

    assign xfer   = i_stb_in && o_ack_in;
    assign o_busy = (state != IDLE);

    always_comb begin
        for (int k = 0; k < IN_CH; k++) begin
            lane[k] = i_data[k*DW +: DW];
        end
    end

    always_comb begin
        mac_sum = '0;
        for (int k = 0; k < IN_CH; k++) begin
            mac_sum = mac_sum + prod(w_mem[w_cnt][k], x_mem[s_cnt][k]);
        end
    end

    genvar g;
    for (g = 0; g < OUT_CH; g++) begin : g_out
        assign o_data[g*DW +: DW] = res[g];
    end

    fc_act_unit #(
        .DW       (DW),
        .FRAC     (FRAC),
        .ACT_MODE (ACT_MODE),
        .NEG_SLOPE(NEG_SLOPE)
    ) u_act (
        .acc (acc),
        .bias(bias_mem[wr_row][wr_col]),
        .y   (act_y)
    );

    // Parameter and input storage is deliberately never cleared by reset.
    always_ff @(posedge clk) begin
        if (RSTn && xfer) begin
            for (int k = 0; k < IN_CH; k++) begin
                if (state == LD_B) begin
                    bias_mem[b_cnt][k] <= lane[k];
                end else if (state == LD_W) begin
                    w_mem[w_cnt][k] <= lane[k];
                end else if (state == RX) begin
                    x_mem[s_cnt][k] <= lane[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            state     <= IDLE;
            b_cnt     <= '0;
            w_cnt     <= '0;
            s_cnt     <= '0;
            n_cnt     <= '0;
            n_row     <= '0;
            n_col     <= '0;
            wr_pend   <= 1'b0;
            wr_n      <= '0;
            wr_row    <= '0;
            wr_col    <= '0;
            tail      <= '0;
            acc       <= '0;
            o_ack_in  <= 1'b0;
            o_stb_out <= 1'b0;
            o_w_valid <= 1'b0;
            for (int n = 0; n < OUT_CH; n++) begin
                res[n] <= '0;
            end
        end else begin
            wr_pend <= 1'b0;
            // Result of the previous neuron lands one cycle after its last MAC.
            if (wr_pend) begin
                res[wr_n] <= act_y;
            end
            unique case (state)
                IDLE: begin
                    if (i_EN_w) begin
                        state     <= LD_B;
                        o_ack_in  <= 1'b1;
                        o_w_valid <= 1'b0;
                        b_cnt     <= '0;
                        w_cnt     <= '0;
                    end else if (i_EN_c) begin
                        state    <= RX;
                        o_ack_in <= 1'b1;
                        s_cnt    <= '0;
                    end
                end
                LD_B: begin
                    if (xfer) begin
                        if (b_cnt == BW'(NB-1)) begin
                            state <= LD_W;
                            b_cnt <= '0;
                        end else begin
                            b_cnt <= b_cnt + 1'b1;
                        end
                    end
                end
                LD_W: begin
                    if (xfer) begin
                        if (w_cnt == WW'(NW-1)) begin
                            state     <= IDLE;
                            o_ack_in  <= 1'b0;
                            o_w_valid <= 1'b1;
                            w_cnt     <= '0;
                        end else begin
                            w_cnt <= w_cnt + 1'b1;
                        end
                    end
                end
                RX: begin
                    if (xfer) begin
                        if (s_cnt == SW'(IN_SEQ-1)) begin
                            state    <= MAC;
                            o_ack_in <= 1'b0;
                            s_cnt    <= '0;
                            w_cnt    <= '0;
                            n_cnt    <= '0;
                            n_row    <= '0;
                            n_col    <= '0;
                            tail     <= '0;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
                MAC: begin
                    if (tail == 2'd0) begin
                        acc   <= ((s_cnt == '0) ? '0 : acc) + mac_sum;
                        w_cnt <= (w_cnt == WW'(NW-1)) ? '0 : w_cnt + 1'b1;
                        if (s_cnt == SW'(IN_SEQ-1)) begin
                            s_cnt   <= '0;
                            wr_pend <= 1'b1;
                            wr_n    <= n_cnt;
                            wr_row  <= n_row;
                            wr_col  <= n_col;
                            n_cnt   <= n_cnt + 1'b1;
                            if (n_col == KW'(IN_CH-1)) begin
                                n_col <= '0;
                                n_row <= n_row + 1'b1;
                            end else begin
                                n_col <= n_col + 1'b1;
                            end
                            if (n_cnt == NNW'(OUT_CH-1)) begin
                                tail <= 2'd1;
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end else if (tail == 2'd1) begin
                        // Last neuron is written this cycle; strobe follows.
                        tail <= 2'd2;
                    end else begin
                        tail      <= '0;
                        state     <= OUT;
                        o_stb_out <= 1'b1;
                    end
                end
                OUT: begin
                    if (i_ack_out) begin
                        o_stb_out <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_tm.sv
// Scoreboard bench for fc_layer_tm: three instances (LeakyReLU, ReLU, none)
// share stimulus; a monitor pops expected vectors whenever o_stb_out is high.
module tb_fc_layer_tm;

    localparam int DW = 32;

    typedef struct {
        logic [63:0] e2;
        logic [63:0] e1;
        logic [63:0] e0;
    } exp_t;

    logic        clk = 1'b0;
    logic        RSTn = 1'b0;
    logic        en_w = 1'b0;
    logic        en_c = 1'b0;
    logic        stb_in = 1'b0;
    logic        ack_out = 1'b0;
    logic [63:0] din = '0;

    logic        busy, w_valid, ack_in, stb_out;
    logic [63:0] dout;
    logic        busy_r, wv_r, ack_r, stb_r;
    logic [63:0] dout_r;
    logic        busy_n, wv_n, ack_n, stb_n;
    logic [63:0] dout_n;

    int   cyc = 0;
    int   last_hs = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fc_layer_tm #(
        .DW(32), .FRAC(15), .IN_CH(2), .IN_SEQ(2), .OUT_CH(2),
        .ACT_MODE(2), .NEG_SLOPE(327)
    ) dut (
        .clk(clk), .RSTn(RSTn), .i_EN_w(en_w), .i_EN_c(en_c),
        .o_busy(busy), .o_w_valid(w_valid), .i_data(din),
        .i_stb_in(stb_in), .o_ack_in(ack_in), .o_data(dout),
        .o_stb_out(stb_out), .i_ack_out(ack_out)
    );

    fc_layer_tm #(
        .DW(32), .FRAC(15), .IN_CH(2), .IN_SEQ(2), .OUT_CH(2),
        .ACT_MODE(1), .NEG_SLOPE(327)
    ) dut_relu (
        .clk(clk), .RSTn(RSTn), .i_EN_w(en_w), .i_EN_c(en_c),
        .o_busy(busy_r), .o_w_valid(wv_r), .i_data(din),
        .i_stb_in(stb_in), .o_ack_in(ack_r), .o_data(dout_r),
        .o_stb_out(stb_r), .i_ack_out(ack_out)
    );

    fc_layer_tm #(
        .DW(32), .FRAC(15), .IN_CH(2), .IN_SEQ(2), .OUT_CH(2),
        .ACT_MODE(0), .NEG_SLOPE(327)
    ) dut_none (
        .clk(clk), .RSTn(RSTn), .i_EN_w(en_w), .i_EN_c(en_c),
        .o_busy(busy_n), .o_w_valid(wv_n), .i_data(din),
        .i_stb_in(stb_in), .o_ack_in(ack_n), .o_data(dout_n),
        .o_stb_out(stb_n), .i_ack_out(ack_out)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act,
                             input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack2(input int a, input int b);
        return {32'(b), 32'(a)};
    endfunction

    // Monitor: compare every cycle the result strobe is up.
    initial begin
        bit   active;
        exp_t cur;
        active = 1'b0;
        cur.e2 = '0;
        cur.e1 = '0;
        cur.e0 = '0;
        forever begin
            @(negedge clk);
            if (stb_out) begin
                if (!active) begin
                    active = 1'b1;
                    if (q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_output: got %h", dout);
                    end else begin
                        cur = q.pop_front();
                        check("latency", 64'(cyc - last_hs), 64'd6);
                    end
                end
                check("data_leaky", dout, cur.e2);
                check("data_relu", dout_r, cur.e1);
                check("data_none", dout_n, cur.e0);
            end else begin
                active = 1'b0;
            end
        end
    end

    // Called and returns at a negedge.
    task automatic send_beat(input logic [63:0] d, input bit rnd);
        int  t;
        bit  done;
        t = 0;
        done = 1'b0;
        while (!done) begin
            if (rnd && $urandom_range(0, 2) == 0) begin
                stb_in = 1'b0;
                din = {$urandom, $urandom};
            end else begin
                stb_in = 1'b1;
                din = d;
                done = ack_in;
                if (done) last_hs = cyc + 1;
            end
            @(negedge clk);
            t++;
            if (!done && t > 100) begin
                n_chk++;
                n_fail++;
                $display("FAIL beat_timeout: got ack 0 expected 1");
                done = 1'b1;
            end
        end
        stb_in = 1'b0;
        din = {$urandom, $urandom};
    endtask

    task automatic start(input bit w, input bit c);
        en_w = w;
        en_c = c;
        @(negedge clk);
        en_w = 1'b0;
        en_c = 1'b0;
    endtask

    task automatic load(input int b0, input int b1, input int w0,
                        input int w1, input bit rnd, input bit both);
        start(1'b1, both);
        send_beat(pack2(b0, b1), rnd);
        for (int s = 0; s < 2; s++) send_beat(pack2(w0, w0), rnd);
        for (int s = 0; s < 2; s++) send_beat(pack2(w1, w1), rnd);
        check_bit("w_valid_after_load", w_valid, 1'b1);
        check_bit("idle_after_load", busy, 1'b0);
    endtask

    task automatic infer(input int x0, input int x1, input int x2,
                         input int x3, input exp_t e, input bit rnd,
                         input bit pulse);
        q.push_back(e);
        start(1'b0, 1'b1);
        send_beat(pack2(x0, x1), rnd);
        send_beat(pack2(x2, x3), rnd);
        if (pulse) begin
            @(negedge clk);
            en_c = 1'b1;
            @(negedge clk);
            en_c = 1'b0;
        end
    endtask

    task automatic drain(input bit hold);
        int t;
        t = 0;
        while (!stb_out && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!stb_out) begin
            n_chk++;
            n_fail++;
            $display("FAIL out_timeout: got stb 0 expected 1");
            return;
        end
        if (hold) begin
            repeat (10) begin
                check_bit("stb_held", stb_out, 1'b1);
                @(negedge clk);
            end
        end
        ack_out = 1'b1;
        @(negedge clk);
        ack_out = 1'b0;
        check_bit("stb_drop", stb_out, 1'b0);
        repeat (3) begin
            check_bit("idle_after_out", busy, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        exp_t e;
        repeat (2) @(negedge clk);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_w_valid", w_valid, 1'b0);
        check_bit("rst_ack_in", ack_in, 1'b0);
        check_bit("rst_stb_out", stb_out, 1'b0);
        check("rst_data", dout, 64'd0);
        RSTn = 1'b1;
        @(negedge clk);

        // Both enables: load must win; weights all 1.0.
        load(8192, 0, 32768, 32768, 1'b0, 1'b1);
        e.e2 = pack2(73728, 65536);
        e.e1 = pack2(73728, 65536);
        e.e0 = pack2(73728, 65536);
        infer(16384, 16384, 16384, 16384, e, 1'b0, 1'b1);
        drain(1'b0);

        // Negative neuron 1 with random input strobes and output stall.
        load(8192, 0, 32768, -32768, 1'b1, 1'b0);
        e.e2 = pack2(73728, -654);
        e.e1 = pack2(73728, 0);
        e.e0 = pack2(73728, -65536);
        infer(16384, 16384, 16384, 16384, e, 1'b1, 1'b0);
        drain(1'b1);

        // Reset in the middle of a weight load.
        start(1'b1, 1'b0);
        send_beat(pack2(0, 0), 1'b0);
        send_beat(pack2(0, 0), 1'b0);
        send_beat(pack2(0, 0), 1'b0);
        RSTn = 1'b0;
        @(negedge clk);
        check_bit("mid_rst_busy", busy, 1'b0);
        check_bit("mid_rst_w_valid", w_valid, 1'b0);
        check_bit("mid_rst_ack_in", ack_in, 1'b0);
        check_bit("mid_rst_stb_out", stb_out, 1'b0);
        check("mid_rst_data", dout, 64'd0);
        RSTn = 1'b1;
        @(negedge clk);

        load(0, -100000, 16384, 32768, 1'b0, 1'b0);
        e.e2 = pack2(28672, -426);
        e.e1 = pack2(28672, 0);
        e.e0 = pack2(28672, -42656);
        infer(16384, 32768, 8192, 0, e, 1'b0, 1'b0);
        drain(1'b0);

        check("queue_empty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule
